fe_instr_queue: RTL and testbench

//  Multi-lane, first-word-fall-through instruction queue for the front end.

---
 rtl/fe_instr_queue_if.sv | 33 +++
 rtl/fe_instr_queue.sv | 85 ++++++++
 tb/tb_fe_instr_queue.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fe_instr_queue_if.sv
// rtl/fe_instr_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface fe_instr_queue_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int ENQ_WIDTH   = 2,
    parameter int DEQ_WIDTH   = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                             flush;
    logic [ENQ_WIDTH-1:0]             enq_valid;
    logic [ENQ_WIDTH*INSTR_WIDTH-1:0] enq_instr;
    logic [ENQ_WIDTH*PC_WIDTH-1:0]    enq_pc;
    logic                             enq_ready;
    logic [DEQ_WIDTH-1:0]             deq_valid;
    logic [DEQ_WIDTH*INSTR_WIDTH-1:0] deq_instr;
    logic [DEQ_WIDTH*PC_WIDTH-1:0]    deq_pc;
    logic [DEQ_WIDTH-1:0]             deq_ready;
    logic [CW-1:0]                    count;
    logic                             full;
    logic                             empty;

    modport slave (
        input  flush, enq_valid, enq_instr, enq_pc, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, count, full, empty
    );

    modport master (
        output flush, enq_valid, enq_instr, enq_pc, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, count, full, empty
    );
endinterface

// File: rtl/fe_instr_queue.sv
// rtl/fe_instr_queue.sv - multi-lane FWFT instruction queue between fetch and decode
module fe_instr_queue #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int ENQ_WIDTH   = 2,
    parameter int DEQ_WIDTH   = 2
) (
    input logic           clk,
    input logic           rst,
    fe_instr_queue_if.slave q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ENQ_C   = CW'(ENQ_WIDTH);

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [PW-1:0]          head_q, tail_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          n_enq, n_enq_eff, n_deq;
    logic                   enq_run, deq_run;

    assign q.enq_ready = !rst && ((DEPTH_C - count_q) >= ENQ_C);
    assign q.count     = rst ? '0 : count_q;
    assign q.full      = !rst && (count_q == DEPTH_C);
    assign q.empty     = rst || (count_q == '0);
    assign n_enq_eff   = q.enq_ready ? n_enq : '0;

    // Only the contiguous run of valid lanes starting at lane 0 is taken.
    always_comb begin
        n_enq   = '0;
        enq_run = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_run && q.enq_valid[i]) n_enq = n_enq + CW'(1);
            else                           enq_run = 1'b0;
        end
    end

    always_comb begin
        q.deq_valid = '0;
        q.deq_instr = '0;
        q.deq_pc    = '0;
        n_deq       = '0;
        deq_run     = 1'b1;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            q.deq_valid[i] = !rst && (count_q > CW'(i));
            if (q.deq_valid[i]) begin
                q.deq_instr[i*INSTR_WIDTH +: INSTR_WIDTH] = instr_mem[head_q + PW'(i)];
                q.deq_pc[i*PC_WIDTH +: PC_WIDTH]          = pc_mem[head_q + PW'(i)];
            end
            if (deq_run && q.deq_valid[i] && q.deq_ready[i]) n_deq = n_deq + CW'(1);
            else                                              deq_run = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_q + PW'(n_enq_eff);
            head_q  <= head_q + PW'(n_deq);
            count_q <= count_q + n_enq_eff - n_deq;
        end
    end

    // Storage is deliberately left uninitialised; validity comes from count.
    always_ff @(posedge clk) begin
        if (!rst && !q.flush) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (CW'(i) < n_enq_eff) begin
                    instr_mem[tail_q + PW'(i)] <= q.enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
                    pc_mem[tail_q + PW'(i)]    <= q.enq_pc[i*PC_WIDTH +: PC_WIDTH];
                end
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
    a_deq_bound:   assert property (@(posedge clk) disable iff (rst) n_deq <= count_q);
    a_depth_pow2:  assert property (@(posedge clk) (DEPTH & (DEPTH - 1)) == 0);
endmodule

// File: tb/tb_fe_instr_queue.sv
// tb/tb_fe_instr_queue.sv - scoreboard bench for fe_instr_queue
module tb_fe_instr_queue;
    localparam int IW    = 32;
    localparam int PCW   = 32;
    localparam int DEPTH = 16;
    localparam int E     = 2;
    localparam int D     = 2;

    typedef struct packed {
        logic [IW-1:0]  instr;
        logic [PCW-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fe_instr_queue_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PCW), .DEPTH(DEPTH),
                        .ENQ_WIDTH(E), .DEQ_WIDTH(D)) q ();

    fe_instr_queue #(.INSTR_WIDTH(IW), .PC_WIDTH(PCW), .DEPTH(DEPTH),
                     .ENQ_WIDTH(E), .DEQ_WIDTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    ent_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   acc_lanes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of entries; occupancy is just its size.
    always @(negedge clk) begin : monitor
        int   sz, ndq, nen;
        bit   run, exp_ready, ev;
        ent_t e;
        sz        = exp_q.size();
        exp_ready = !rst && ((DEPTH - sz) >= E);
        check("count", 64'(q.count), rst ? 64'd0 : 64'(sz));
        check("full", 64'(q.full), 64'(!rst && sz == DEPTH));
        check("empty", 64'(q.empty), 64'(rst || sz == 0));
        check("enq_ready", 64'(q.enq_ready), 64'(exp_ready));
        ndq = 0;
        run = 1'b1;
        for (int i = 0; i < D; i++) begin
            ev = !rst && (sz > i);
            e  = ev ? exp_q[i] : '0;
            check($sformatf("deq_valid[%0d]", i), 64'(q.deq_valid[i]), 64'(ev));
            check($sformatf("deq_instr[%0d]", i), 64'(q.deq_instr[i*IW +: IW]), 64'(e.instr));
            check($sformatf("deq_pc[%0d]", i), 64'(q.deq_pc[i*PCW +: PCW]), 64'(e.pc));
            if (run && ev && q.deq_ready[i]) ndq++;
            else run = 1'b0;
        end
        if (rst || q.flush) begin
            exp_q.delete();
            acc_lanes = 0;
        end else begin
            repeat (ndq) void'(exp_q.pop_front());
            nen = 0;
            run = 1'b1;
            for (int i = 0; i < E; i++) begin
                if (run && q.enq_valid[i]) nen++;
                else run = 1'b0;
            end
            acc_lanes = exp_ready ? nen : 0;
        end
    end

    task automatic step();
        ent_t e;
        @(posedge clk);
        for (int i = 0; i < acc_lanes; i++) begin
            e.instr = q.enq_instr[i*IW +: IW];
            e.pc    = q.enq_pc[i*PCW +: PCW];
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic enq2(input logic [1:0] v, input logic [31:0] pc0);
        q.enq_valid = v;
        q.enq_instr = {$urandom(), $urandom()};
        q.enq_pc    = {pc0 + 32'd4, pc0};
    endtask

    initial begin
        q.flush     = 1'b0;
        q.enq_valid = '0;
        q.enq_instr = '0;
        q.enq_pc    = '0;
        q.deq_ready = '0;
        rst         = 1'b1;
        repeat (3) step();
        check("rst_enq_ready", 64'(q.enq_ready), 64'd0);
        rst = 1'b0;
        step();

        // 1: two-lane enqueue visible one cycle later
        q.enq_valid = 2'b11;
        q.enq_instr = {32'h00B00113, 32'h00A00093};
        q.enq_pc    = {32'h4, 32'h0};
        step();
        q.enq_valid = '0;
        check("t1_deq_valid", 64'(q.deq_valid), 64'd3);
        check("t1_pc0", 64'(q.deq_pc[31:0]), 64'h0);
        check("t1_pc1", 64'(q.deq_pc[63:32]), 64'h4);
        check("t1_instr0", 64'(q.deq_instr[31:0]), 64'h00A00093);
        check("t1_count", 64'(q.count), 64'd2);
        q.deq_ready = 2'b11;
        step();
        q.deq_ready = '0;

        // 2: fill to full, then extra enq is ignored
        for (int k = 0; k < 7; k++) begin
            enq2(2'b11, 32'(8 * k));
            step();
        end
        check("t2_count14", 64'(q.count), 64'd14);
        check("t2_ready14", 64'(q.enq_ready), 64'd1);
        enq2(2'b11, 32'h38);
        step();
        check("t2_count16", 64'(q.count), 64'd16);
        check("t2_full", 64'(q.full), 64'd1);
        check("t2_ready16", 64'(q.enq_ready), 64'd0);
        enq2(2'b11, 32'h900);
        repeat (2) step();
        check("t2_count_hold", 64'(q.count), 64'd16);

        // 3: drain 12, refill across the wrap, drain in PC order
        q.enq_valid = '0;
        q.deq_ready = 2'b11;
        repeat (6) step();
        q.deq_ready = '0;
        check("t3_count4", 64'(q.count), 64'd4);
        for (int k = 0; k < 6; k++) begin
            enq2(2'b11, 32'h40 + 32'(8 * k));
            step();
        end
        q.enq_valid = '0;
        q.deq_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            check("t3_order0", 64'(q.deq_pc[31:0]), 64'(32'h30 + 32'(8 * k)));
            check("t3_order1", 64'(q.deq_pc[63:32]), 64'(32'h34 + 32'(8 * k)));
            step();
        end
        q.deq_ready = '0;
        check("t3_empty", 64'(q.empty), 64'd1);

        // 4: non-prefix valid / ready patterns do nothing
        enq2(2'b10, 32'h100);
        step();
        check("t4_enq10", 64'(q.count), 64'd0);
        enq2(2'b11, 32'h100);
        step();
        q.enq_valid = '0;
        q.deq_ready = 2'b10;
        step();
        check("t4_deq10", 64'(q.count), 64'd2);
        q.deq_ready = '0;

        // 5: flush beats same-cycle enq and deq
        enq2(2'b11, 32'h200);
        step();
        enq2(2'b01, 32'h208);
        step();
        check("t5_count5", 64'(q.count), 64'd5);
        q.flush = 1'b1;
        enq2(2'b11, 32'h300);
        q.deq_ready = 2'b11;
        step();
        q.flush     = 1'b0;
        q.enq_valid = '0;
        q.deq_ready = '0;
        check("t5_count0", 64'(q.count), 64'd0);
        check("t5_empty", 64'(q.empty), 64'd1);
        check("t5_deq_valid", 64'(q.deq_valid), 64'd0);

        // 6: reset mid-stream
        for (int k = 0; k < 4; k++) begin
            enq2(2'b11, 32'h400 + 32'(8 * k));
            step();
        end
        enq2(2'b01, 32'h420);
        step();
        check("t6_count9", 64'(q.count), 64'd9);
        rst = 1'b1;
        enq2(2'b11, 32'h500);
        step();
        check("t6_count_rst", 64'(q.count), 64'd0);
        check("t6_ready_rst", 64'(q.enq_ready), 64'd0);
        rst = 1'b0;
        q.enq_valid = '0;
        #1;
        check("t6_ready_after", 64'(q.enq_ready), 64'd1);
        step();

        // Random traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            q.enq_valid = E'($urandom());
            q.enq_instr = {$urandom(), $urandom()};
            q.enq_pc    = {$urandom(), $urandom()};
            q.deq_ready = D'($urandom());
            q.flush     = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end
        rst         = 1'b0;
        q.flush     = 1'b0;
        q.enq_valid = '0;
        q.deq_ready = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
